// File: rtl/modmul_pipe.sv
// modmul_pipe: LANES parallel (a*b) mod Q multipliers, 3-stage Barrett pipeline with valid/ready.
// Optional macro MODMUL_PIPE_ERR_EN adds per-lane out_err flags for operands >= Q.
module modmul_pipe #(
   parameter int unsigned W     = 12,
   parameter int unsigned Q     = 3329,
   parameter int unsigned LANES = 2,
   parameter int unsigned TAG_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [LANES*W-1:0]   in_a,
   input  logic [LANES*W-1:0]   in_b,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LANES*W-1:0]   out_c,
   output logic [TAG_W-1:0]     out_tag,
   output logic [LANES-1:0]     out_err
);
   // Remainder after the quotient estimate is < 2Q < 2^(W+1), so W+2 bits suffice mod 2^(W+2).
   localparam int unsigned    RW     = W + 2;
   localparam logic [2*W:0]   POW2   = {1'b1, {(2*W){1'b0}}};
   localparam logic [2*W:0]   M_FULL = POW2 / (2*W+1)'(Q);
   localparam logic [2*W-1:0] BAR_M  = M_FULL[2*W-1:0];
   localparam logic [RW-1:0]  Q_R    = RW'(Q);

   logic              w_adv;
   logic              r_v1, r_v2, r_v3;
   logic [TAG_W-1:0]  r_t1, r_t2, r_t3;
   logic [2*W-1:0]    r_p   [LANES];
   logic [RW-1:0]     r_q   [LANES];
   logic [RW-1:0]     r_plo [LANES];
   logic [W-1:0]      r_c   [LANES];
   logic [RW-1:0]     w_q   [LANES];
   logic [RW-1:0]     w_r   [LANES];
   logic [RW-1:0]     w_r1  [LANES];
   logic [W-1:0]      w_c   [LANES];

   assign w_adv     = !r_v3 || out_ready;
   assign in_ready  = w_adv;
   assign out_valid = r_v3;
   assign out_tag   = r_t3;

   always_comb begin
      out_c = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         w_q[i]  = RW'(((4*W)'(r_p[i]) * (4*W)'(BAR_M)) >> (2*W));
         w_r[i]  = r_plo[i] - r_q[i] * Q_R;
         w_r1[i] = (w_r[i] >= Q_R) ? w_r[i] - Q_R : w_r[i];
         w_c[i]  = W'((w_r1[i] >= Q_R) ? w_r1[i] - Q_R : w_r1[i]);
         out_c[i*W +: W] = r_c[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1 <= 1'b0;
         r_v2 <= 1'b0;
         r_v3 <= 1'b0;
         r_t1 <= '0;
         r_t2 <= '0;
         r_t3 <= '0;
         for (int unsigned i = 0; i < LANES; i++) begin
            r_p[i]   <= '0;
            r_q[i]   <= '0;
            r_plo[i] <= '0;
            r_c[i]   <= '0;
         end
      end else if (w_adv) begin
         r_v1 <= in_valid;
         r_v2 <= r_v1;
         r_v3 <= r_v2;
         r_t1 <= in_tag;
         r_t2 <= r_t1;
         r_t3 <= r_t2;
         for (int unsigned i = 0; i < LANES; i++) begin
            r_p[i]   <= (2*W)'(in_a[i*W +: W]) * (2*W)'(in_b[i*W +: W]);
            r_q[i]   <= w_q[i];
            r_plo[i] <= r_p[i][RW-1:0];
            r_c[i]   <= w_c[i];
         end
      end
   end

`ifdef MODMUL_PIPE_ERR_EN
   logic [LANES-1:0] w_e, r_e1, r_e2, r_e3;

   always_comb begin
      w_e = '0;
      for (int unsigned i = 0; i < LANES; i++)
         w_e[i] = (in_a[i*W +: W] >= W'(Q)) || (in_b[i*W +: W] >= W'(Q));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_e1 <= '0;
         r_e2 <= '0;
         r_e3 <= '0;
      end else if (w_adv) begin
         r_e1 <= w_e;
         r_e2 <= r_e1;
         r_e3 <= r_e2;
      end
   end

   assign out_err = r_e3;
`else
   assign out_err = '0;
`endif

endmodule
